sram_arbiter_rr: RTL and testbench
==================================

// Module: sram_arbiter_rr
// PURPOSE
//  Multi-client arbiter for the external async 16-bit SRAM (IS61-style, UB/LB byte lanes).
//  NUM_CH clients (renderer writers, VGA reader, ...) issue req/we/addr/wdata/be.
//  The arbiter grants round-robin, sequences a 2-cycle SRAM access and returns read data with rvalid.
//  It sits between the pixel producers/consumers and the SRAM_* top-level pins.
// PARAMETERS
//  ADDR_W   18  SRAM word-address width
//  NUM_CH   4   client count, 2..8
//  TURN     1   idle bus-turnaround cycles inserted after every write, 0..3
// PORTS
//  CLOCK_50   in     1            system clock; all logic on posedge
//  reset_n    in     1            synchronous, active-low reset
//  req        in     NUM_CH       per-client request; held until gnt
//  we         in     NUM_CH       1 = write, 0 = read
//  addr       in     NUM_CH*ADDR_W  client i at [i*ADDR_W +: ADDR_W]
//  wdata      in     NUM_CH*16    client i at [i*16 +: 16]
//  be         in     NUM_CH*2     byte enables; bit1 = upper byte, bit0 = lower byte
//  gnt        out    NUM_CH       one-hot, 1-cycle pulse: request accepted
//  rvalid     out    NUM_CH       one-hot, 1-cycle pulse: rdata valid for that client
//  rdata      out    16           shared read-data register
//  SRAM_ADDR  out    ADDR_W       SRAM address
//  SRAM_DQ    inout  16           SRAM data; high-Z unless writing
//  SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1  active-low SRAM strobes
// BEHAVIOUR
//  - Reset values: state=IDLE, rr_ptr=0, gnt=0, rvalid=0, rdata=0, SRAM_ADDR=0, all *_N=1, DQ=Z.
//  - States are IDLE, SETUP, ACCESS, TURN. Every output is registered.
//  - Arbitration is evaluated at an edge in IDLE, or at the edge that ends ACCESS when no TURN is pending.
//    - Winner: first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
//    - The winner's we/addr/wdata/be are latched. Next state is SETUP and gnt[winner]=1 for that cycle.
//    - rr_ptr <= (winner+1) mod NUM_CH.
//    - With no req: stay/return IDLE, strobes high.
//  - SETUP (1 cycle):
//    - SRAM_ADDR = latched addr, CE_N=0, UB_N=~be[1], LB_N=~be[0].
//    - Read: OE_N=0, DQ=Z.
//    - Write: OE_N=1, DQ=wdata, WE_N=1.
//  - ACCESS (1 cycle): same as SETUP, except on a write WE_N=0.
//    - Read: DQ is captured into rdata at the edge ending ACCESS, and rvalid[winner]=1 in the following cycle.
//  - After a write with TURN>0: TURN cycles in TURN state (DQ=Z, strobes high), then arbitration.
//    With TURN=0, arbitration happens directly at the end of ACCESS.
//  - Latency:
//    - req sampled at edge k -> gnt in cycle k+1 -> ACCESS in cycle k+2 -> rdata/rvalid in cycle k+3.
//    - Peak throughput is one access per 2 cycles (reads, or writes with TURN=0).
//  - Handshake:
//    - Clients keep req and payload stable until they see gnt.
//    - In the gnt cycle a client may present its next request; it is eligible at the next arbitration edge.
//    - A req dropped before it is granted is simply never granted.
//    - Requests are never merged or reordered within one client.
//  - Reads and writes share rdata. rdata holds its value until the next read capture.
//  - be=2'b00 still performs the cycle (no byte written or read); gnt and rvalid still pulse.
//  - rr_ptr wraps NUM_CH-1 -> 0. Fairness: a continuously requesting client waits at most NUM_CH-1 grants.
//  - Reset mid-operation (reset_n=0 at any edge) returns to the reset values at that edge.
//    WE_N deasserts, DQ releases, and a pending rvalid is dropped.
// CONFIGURATION
//  VIDEO_PRIO_EN defined:
//    - Client 0 (VGA scan reader) wins every arbitration in which req[0]=1.
//    - Clients 1..NUM_CH-1 round-robin among themselves.
//    - rr_ptr advances only on grants to clients 1..NUM_CH-1.
//  VIDEO_PRIO_EN undefined: pure round-robin over all NUM_CH clients, as above.
// TESTING
//  1. Reset: reset_n=0 for 2 cycles with req=4'hF
//     -> gnt=0, rvalid=0, WE_N=OE_N=CE_N=1, DQ=Z, SRAM_ADDR=0.
//  2. Single write then read, TURN=1:
//     - ch1 writes addr 0x00123, data 0xA5C3, be=11 -> gnt[1] one cycle after req.
//       WE_N low only in ACCESS; then 1 TURN cycle.
//     - ch1 reads 0x00123 -> rvalid[1] 3 cycles after req, rdata=0xA5C3.
//  3. Byte lanes:
//     - Write 0xFFFF, then write 0x1200 with be=10.
//     - Read back -> 0x12FF; UB_N=0, LB_N=1 during the second write.
//  4. Round-robin: all four clients request reads continuously, rr_ptr=0
//     - gnt order 0,1,2,3,0,...
//     - Grants spaced 2 cycles apart; each rvalid targets the matching client.
//  5. VIDEO_PRIO_EN: req[0] held high and req[2] held high
//     -> every grant goes to client 0. Drop req[0] -> client 2 is granted at the next arbitration.
//  6. Reset during a write ACCESS (reset_n=0 at the ACCESS edge)
//     - At the next cycle WE_N=1, DQ=Z, no rvalid; the target address is unchanged or fully written, never partial.

Source files
------------

// File: rtl/sram_arbiter_rr.sv
// sram_arbiter_rr: round-robin arbiter in front of an asynchronous 16-bit SRAM
// with UB/LB byte lanes. Each granted access is sequenced as SETUP + ACCESS.
// Read data is returned through a shared rdata register with a one-hot rvalid.
// Writes can be followed by TURN idle cycles, which let the data bus turn around.
// Every output, including the SRAM strobes and the DQ drive enable, is registered.
// Optional build macro VIDEO_PRIO_EN: client 0 wins every arbitration it takes
// part in, and clients 1..NUM_CH-1 share the round-robin between themselves.
module sram_arbiter_rr #(
    parameter int ADDR_W = 18,
    parameter int NUM_CH = 4,
    parameter int TURN   = 1
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*16-1:0]     wdata,
    input  logic [NUM_CH*2-1:0]      be,
    output logic [NUM_CH-1:0]        gnt,
    output logic [NUM_CH-1:0]        rvalid,
    output logic [15:0]              rdata,
    output logic [ADDR_W-1:0]        SRAM_ADDR,
    inout  wire  [15:0]              SRAM_DQ,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_TURN   = 2'd3
    } state_t;

    // Per-client views of the packed request payload buses.
    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [15:0]       ch_wdata [NUM_CH];
    logic [1:0]        ch_be    [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_addr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign ch_wdata[gi] = wdata[gi*16 +: 16];
        assign ch_be[gi]    = be[gi*2 +: 2];
    end

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [1:0]         turn_cnt_reg, turn_cnt_next;
    logic               lat_we_reg, lat_we_next;
    logic [ADDR_W-1:0]  lat_addr_reg, lat_addr_next;
    logic [15:0]        lat_wdata_reg, lat_wdata_next;
    logic [1:0]         lat_be_reg, lat_be_next;
    logic [PTR_W-1:0]   lat_ch_reg, lat_ch_next;
    logic [NUM_CH-1:0]  gnt_reg, gnt_next;
    logic [NUM_CH-1:0]  rvalid_reg, rvalid_next;
    logic [15:0]        rdata_reg, rdata_next;
    logic [ADDR_W-1:0]  sram_addr_reg, sram_addr_next;
    logic               we_n_reg, we_n_next;
    logic               oe_n_reg, oe_n_next;
    logic               ce_n_reg, ce_n_next;
    logic               ub_n_reg, ub_n_next;
    logic               lb_n_reg, lb_n_next;
    logic               dq_oe_reg, dq_oe_next;
    logic [15:0]        dq_out_reg, dq_out_next;

    logic [NUM_CH-1:0]  arb_req;
    logic               arb_found;
    logic [PTR_W-1:0]   arb_win;
    logic               do_arb;

    // Returns the client index at position k of the scan that starts at base, wrapping modulo NUM_CH.
    function automatic logic [PTR_W-1:0] scan_idx(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return PTR_W'(s);
    endfunction

    // Returns the pointer value after a grant to client w: w+1, wrapping from NUM_CH-1 to 0.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] w);
        int s;
        s = int'(w) + 1;
        if (s >= NUM_CH) s = 0;
        return PTR_W'(s);
    endfunction

    // Selects the winner: the first requester in scan order starting at rr_ptr.
    // The scan runs backwards so that the last match found is the first in scan order.
    always_comb begin
        arb_req = req;
`ifdef VIDEO_PRIO_EN
        arb_req[0] = 1'b0;
`endif
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (arb_req[scan_idx(rr_ptr_reg, k)]) begin
                arb_found = 1'b1;
                arb_win   = scan_idx(rr_ptr_reg, k);
            end
        end
`ifdef VIDEO_PRIO_EN
        if (req[0]) begin
            arb_found = 1'b1;
            arb_win   = '0;
        end
`endif
    end

    // Computes the next state and the next value of every registered output.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        turn_cnt_next  = turn_cnt_reg;
        lat_we_next    = lat_we_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;
        lat_be_next    = lat_be_reg;
        lat_ch_next    = lat_ch_reg;
        gnt_next       = '0;
        rvalid_next    = '0;
        rdata_next     = rdata_reg;
        sram_addr_next = sram_addr_reg;
        we_n_next      = 1'b1;
        oe_n_next      = 1'b1;
        ce_n_next      = 1'b1;
        ub_n_next      = 1'b1;
        lb_n_next      = 1'b1;
        dq_oe_next     = 1'b0;
        dq_out_next    = dq_out_reg;
        do_arb         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                do_arb = 1'b1;
            end
            S_SETUP: begin
                // Outputs for the ACCESS cycle: same as SETUP, but WE_N falls on a write.
                state_next     = S_ACCESS;
                sram_addr_next = lat_addr_reg;
                ce_n_next      = 1'b0;
                ub_n_next      = ~lat_be_reg[1];
                lb_n_next      = ~lat_be_reg[0];
                oe_n_next      = lat_we_reg;
                we_n_next      = ~lat_we_reg;
                dq_oe_next     = lat_we_reg;
                dq_out_next    = lat_wdata_reg;
            end
            S_ACCESS: begin
                if (!lat_we_reg) begin
                    rdata_next              = SRAM_DQ;
                    rvalid_next[lat_ch_reg] = 1'b1;
                end
                if (lat_we_reg && (TURN > 0)) begin
                    state_next    = S_TURN;
                    turn_cnt_next = 2'(TURN - 1);
                end else begin
                    do_arb = 1'b1;
                end
            end
            S_TURN: begin
                if (turn_cnt_reg == 2'd0) begin
                    do_arb = 1'b1;
                end else begin
                    turn_cnt_next = turn_cnt_reg - 2'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (do_arb) begin
            if (arb_found) begin
                state_next         = S_SETUP;
                gnt_next[arb_win]  = 1'b1;
                lat_we_next        = we[arb_win];
                lat_addr_next      = ch_addr[arb_win];
                lat_wdata_next     = ch_wdata[arb_win];
                lat_be_next        = ch_be[arb_win];
                lat_ch_next        = arb_win;
`ifdef VIDEO_PRIO_EN
                if (arb_win != '0) rr_ptr_next = ptr_after(arb_win);
`else
                rr_ptr_next        = ptr_after(arb_win);
`endif
                // Outputs for the SETUP cycle.
                sram_addr_next     = ch_addr[arb_win];
                ce_n_next          = 1'b0;
                ub_n_next          = ~ch_be[arb_win][1];
                lb_n_next          = ~ch_be[arb_win][0];
                oe_n_next          = we[arb_win];
                we_n_next          = 1'b1;
                dq_oe_next         = we[arb_win];
                dq_out_next        = ch_wdata[arb_win];
            end else begin
                state_next = S_IDLE;
            end
        end
    end

    // State, payload latch and output registers; the reset returns every output to its idle value.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= '0;
            turn_cnt_reg  <= '0;
            lat_we_reg    <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            lat_be_reg    <= '0;
            lat_ch_reg    <= '0;
            gnt_reg       <= '0;
            rvalid_reg    <= '0;
            rdata_reg     <= '0;
            sram_addr_reg <= '0;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            ce_n_reg      <= 1'b1;
            ub_n_reg      <= 1'b1;
            lb_n_reg      <= 1'b1;
            dq_oe_reg     <= 1'b0;
            dq_out_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            turn_cnt_reg  <= turn_cnt_next;
            lat_we_reg    <= lat_we_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
            lat_be_reg    <= lat_be_next;
            lat_ch_reg    <= lat_ch_next;
            gnt_reg       <= gnt_next;
            rvalid_reg    <= rvalid_next;
            rdata_reg     <= rdata_next;
            sram_addr_reg <= sram_addr_next;
            we_n_reg      <= we_n_next;
            oe_n_reg      <= oe_n_next;
            ce_n_reg      <= ce_n_next;
            ub_n_reg      <= ub_n_next;
            lb_n_reg      <= lb_n_next;
            dq_oe_reg     <= dq_oe_next;
            dq_out_reg    <= dq_out_next;
        end
    end

    assign gnt       = gnt_reg;
    assign rvalid    = rvalid_reg;
    assign rdata     = rdata_reg;
    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_CE_N = ce_n_reg;
    assign SRAM_UB_N = ub_n_reg;
    assign SRAM_LB_N = lb_n_reg;
    assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter_rr.sv
// Testbench for sram_arbiter_rr. It contains a behavioural SRAM model, a table of
// isolated single transactions, hand-written sequences for round-robin order,
// priority and reset, and a randomized multi-client run. The random run is checked
// against a transaction-level reference model.
module tb_sram_arbiter_rr;

    localparam int ADDR_W  = 18;
    localparam int NUM_CH  = 4;
    localparam int TURN    = 1;
    localparam int RND_CYC = 600;
`ifdef VIDEO_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic                     reset_n;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        we;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*16-1:0]     wdata;
    logic [NUM_CH*2-1:0]      be;
    wire  [NUM_CH-1:0]        gnt;
    wire  [NUM_CH-1:0]        rvalid;
    wire  [15:0]              rdata;
    wire  [ADDR_W-1:0]        sram_addr;
    wire  [15:0]              sram_dq;
    wire                      sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    sram_arbiter_rr #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .TURN(TURN)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .be       (be),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .SRAM_ADDR(sram_addr),
        .SRAM_DQ  (sram_dq),
        .SRAM_WE_N(sram_we_n),
        .SRAM_OE_N(sram_oe_n),
        .SRAM_CE_N(sram_ce_n),
        .SRAM_UB_N(sram_ub_n),
        .SRAM_LB_N(sram_lb_n)
    );

    // ---------------- asynchronous SRAM model ----------------
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic        mem_init = 1'b0;
    logic        drv_en   = 1'b0;
    logic [15:0] drv_val  = 16'h0000;

    assign sram_dq = (drv_en && !sram_ce_n && !sram_oe_n && sram_we_n) ? drv_val : 16'hzzzz;

    // The model acts in mid-cycle: it applies writes while WE_N is low and fetches the read word.
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 16'h0000;
            mem_init <= 1'b1;
            drv_en   <= 1'b0;
        end else begin
            if (!sram_ce_n && !sram_we_n) begin
                if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
                if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
            end
            drv_en  <= !sram_ce_n && !sram_oe_n && sram_we_n;
            drv_val <= mem[sram_addr];
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Runs one isolated transaction while the arbiter is idle and checks it cycle by cycle.
    task automatic do_txn(input int ch, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [15:0] d, input logic [1:0] b,
                          input logic chk_rd, input logic [15:0] exp, output logic [15:0] got);
        logic [NUM_CH-1:0] oh;
        oh = NUM_CH'(1) << ch;
        got = 16'h0000;
        clear_inputs();
        req[ch] = 1'b1;
        we[ch]  = w;
        addr[ch*ADDR_W +: ADDR_W] = a;
        wdata[ch*16 +: 16] = d;
        be[ch*2 +: 2] = b;
        @(posedge clk); #1;
        check("txn_gnt", 32'(gnt), 32'(oh));
        check("setup_ce_n", 32'(sram_ce_n), 0);
        check("setup_addr", 32'(sram_addr), 32'(a));
        check("setup_we_n", 32'(sram_we_n), 1);
        check("setup_oe_n", 32'(sram_oe_n), 32'(w));
        check("setup_ub_n", 32'(sram_ub_n), 32'(!b[1]));
        check("setup_lb_n", 32'(sram_lb_n), 32'(!b[0]));
        req = '0;
        @(posedge clk); #1;
        check("access_gnt", 32'(gnt), 0);
        check("access_we_n", 32'(sram_we_n), 32'(!w));
        check("access_ce_n", 32'(sram_ce_n), 0);
        check("access_ub_n", 32'(sram_ub_n), 32'(!b[1]));
        check("access_lb_n", 32'(sram_lb_n), 32'(!b[0]));
        @(posedge clk); #1;
        if (!w) begin
            check("txn_rvalid", 32'(rvalid), 32'(oh));
            got = rdata;
            if (chk_rd) check("txn_rdata", 32'(rdata), 32'(exp));
        end else begin
            check("turn_rvalid", 32'(rvalid), 0);
            check("turn_we_n", 32'(sram_we_n), 1);
            check("turn_ce_n", 32'(sram_ce_n), 1);
        end
        @(posedge clk); #1;
        check("idle_rvalid", 32'(rvalid), 0);
        check("idle_ce_n", 32'(sram_ce_n), 1);
        $display("txn ch%0d %s addr=%05h wdata=%04h be=%b rdata=%04h", ch, w ? "WR" : "RD", a, d, b, got);
    endtask

    // Expected client of the k-th grant when all clients request continuously from pointer 0.
    function automatic int rr_exp(input int k);
        return PRIO ? 0 : (k % NUM_CH);
    endfunction

    // ---------------- table of isolated transactions ----------------
    typedef struct {
        int                ch;
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
        logic [1:0]        b;
        logic [15:0]       exp;
    } vec_t;

    vec_t tbl [11];

    // ---------------- random-phase reference model state ----------------
    typedef struct {
        int          due;
        int          ch;
        logic [15:0] data;
    } rv_t;

    rv_t               rvq [$];
    logic [15:0]       ref_mem [int];
    logic              c_act   [NUM_CH];
    logic              c_we    [NUM_CH];
    logic [ADDR_W-1:0] c_addr  [NUM_CH];
    logic [15:0]       c_wd    [NUM_CH];
    logic [1:0]        c_be    [NUM_CH];
    int                ptr_m, next_arb, ecnt, win;
    logic              found;
    logic [NUM_CH-1:0] rq_s, eg, erv;
    logic [15:0]       got;

    function automatic logic [15:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
    endfunction

    task automatic new_req(input int i);
        c_act[i]  = 1'b1;
        c_we[i]   = 1'($urandom_range(0, 1));
        c_addr[i] = 18'h01000 | ADDR_W'($urandom_range(0, 3) << 12) | ADDR_W'($urandom_range(0, 7));
        c_wd[i]   = 16'($urandom);
        c_be[i]   = c_we[i] ? 2'($urandom_range(0, 3)) : 2'b11;
    endtask

    task automatic drive_clients();
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = c_act[i];
            we[i]  = c_we[i];
            addr[i*ADDR_W +: ADDR_W] = c_addr[i];
            wdata[i*16 +: 16] = c_wd[i];
            be[i*2 +: 2] = c_be[i];
        end
    endtask

    initial begin
        tbl[0]  = '{1, 1'b1, 18'h00123, 16'hA5C3, 2'b11, 16'h0000};
        tbl[1]  = '{1, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hA5C3};
        tbl[2]  = '{2, 1'b1, 18'h00040, 16'hFFFF, 2'b11, 16'h0000};
        tbl[3]  = '{3, 1'b1, 18'h00040, 16'h1200, 2'b10, 16'h0000};
        tbl[4]  = '{0, 1'b0, 18'h00040, 16'h0000, 2'b11, 16'h12FF};
        tbl[5]  = '{0, 1'b1, 18'h00040, 16'hABCD, 2'b01, 16'h0000};
        tbl[6]  = '{2, 1'b0, 18'h00040, 16'h0000, 2'b11, 16'h12CD};
        tbl[7]  = '{3, 1'b1, 18'h3FFFF, 16'h5A5A, 2'b11, 16'h0000};
        tbl[8]  = '{1, 1'b1, 18'h3FFFF, 16'h0000, 2'b00, 16'h0000};
        tbl[9]  = '{3, 1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'h5A5A};
        tbl[10] = '{0, 1'b0, 18'h00000, 16'h0000, 2'b11, 16'h0000};

        // Reset with every client requesting.
        reset_n = 1'b0;
        clear_inputs();
        req = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_oe_n", 32'(sram_oe_n), 1);
        check("rst_ce_n", 32'(sram_ce_n), 1);
        check("rst_ub_lb_n", 32'({sram_ub_n, sram_lb_n}), 3);
        check("rst_addr", 32'(sram_addr), 0);
        req = '0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single transactions from the table.
        for (int t = 0; t < 11; t++) begin
            do_txn(tbl[t].ch, tbl[t].w, tbl[t].a, tbl[t].d, tbl[t].b, !tbl[t].w, tbl[t].exp, got);
        end

        // Round-robin: every client reads continuously, starting from pointer 0.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            addr[i*ADDR_W +: ADDR_W] = 18'h00100 + ADDR_W'(i);
            be[i*2 +: 2] = 2'b11;
        end
        req = '1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk); #1;
            check("rr_gnt", 32'(gnt), (cyc % 2 == 0) ? (32'd1 << rr_exp(cyc / 2)) : 32'd0);
            check("rr_rvalid", 32'(rvalid),
                  (cyc >= 2 && cyc % 2 == 0) ? (32'd1 << rr_exp(cyc / 2 - 1)) : 32'd0);
            if (gnt != '0) $display("rr txn grant=%b rvalid=%b", gnt, rvalid);
        end
        req = '0;
        repeat (4) @(posedge clk);
        #1;

`ifdef VIDEO_PRIO_EN
        // Client 0 holds off client 2 until it drops its request.
        do_reset();
        be = '1;
        req = 4'b0101;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            check("prio_gnt", 32'(gnt), (cyc % 2 == 0) ? 32'd1 : 32'd0);
            if (cyc == 5) req[0] = 1'b0;
        end
        @(posedge clk); #1;
        check("prio_gnt_ch2", 32'(gnt), 32'd4);
        req = '0;
        repeat (4) @(posedge clk);
        #1;
`endif

        // Reset during a write ACCESS: the word ends up either old or fully new.
        do_reset();
        do_txn(2, 1'b1, 18'h00200, 16'h1111, 2'b11, 1'b0, 16'h0000, got);
        clear_inputs();
        req[2] = 1'b1; we[2] = 1'b1;
        addr[2*ADDR_W +: ADDR_W] = 18'h00200;
        wdata[2*16 +: 16] = 16'hEEEE;
        be[2*2 +: 2] = 2'b11;
        @(posedge clk); #1;
        check("rstw_gnt", 32'(gnt), 32'd4);
        req = '0;
        @(posedge clk); #1;
        check("rstw_access_we_n", 32'(sram_we_n), 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rstw_we_n", 32'(sram_we_n), 1);
        check("rstw_ce_n", 32'(sram_ce_n), 1);
        check("rstw_oe_n", 32'(sram_oe_n), 1);
        check("rstw_gnt0", 32'(gnt), 0);
        check("rstw_rvalid", 32'(rvalid), 0);
        check("rstw_addr", 32'(sram_addr), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_txn(2, 1'b0, 18'h00200, 16'h0000, 2'b11, 1'b0, 16'h0000, got);
        check("rstw_atomic", 32'(got == 16'h1111 || got == 16'hEEEE), 1);

        // Reset during a read ACCESS drops the pending rvalid.
        clear_inputs();
        req[1] = 1'b1;
        addr[1*ADDR_W +: ADDR_W] = 18'h00123;
        be[1*2 +: 2] = 2'b11;
        @(posedge clk); #1;
        check("rstr_gnt", 32'(gnt), 32'd2);
        req = '0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rstr_rvalid", 32'(rvalid), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rstr_rvalid_after", 32'(rvalid), 0);
        check("rstr_gnt_after", 32'(gnt), 0);

        // Randomized clients checked against the transaction-level reference model.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            c_act[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wd[i] = '0; c_be[i] = '0;
        end
        ptr_m = 0;
        ecnt = 0;
        next_arb = 1;
        drive_clients();
        for (int cyc = 0; cyc < RND_CYC + 12; cyc++) begin
            @(posedge clk); #1;
            ecnt++;
            rq_s = req;
            eg   = '0;
            erv  = '0;
            if (ecnt == next_arb) begin
                found = 1'b0;
                win   = 0;
                if (PRIO && rq_s[0]) begin
                    found = 1'b1;
                    win   = 0;
                end else begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        int idx;
                        idx = (ptr_m + k) % NUM_CH;
                        if (!found && rq_s[idx] && !(PRIO && idx == 0)) begin
                            found = 1'b1;
                            win   = idx;
                        end
                    end
                end
                if (found) begin
                    eg = NUM_CH'(1) << win;
                    if (!PRIO || win != 0) ptr_m = (win + 1) % NUM_CH;
                    if (c_we[win]) begin
                        logic [15:0] v;
                        v = ref_rd(c_addr[win]);
                        if (c_be[win][1]) v[15:8] = c_wd[win][15:8];
                        if (c_be[win][0]) v[7:0]  = c_wd[win][7:0];
                        ref_mem[int'(c_addr[win])] = v;
                        next_arb = ecnt + 2 + TURN;
                    end else begin
                        rvq.push_back('{ecnt + 2, win, ref_rd(c_addr[win])});
                        next_arb = ecnt + 2;
                    end
                end else begin
                    next_arb = ecnt + 1;
                end
            end
            check("rnd_gnt", 32'(gnt), 32'(eg));
            if (rvq.size() > 0 && rvq[0].due == ecnt) begin
                erv = NUM_CH'(1) << rvq[0].ch;
                check("rnd_rdata", 32'(rdata), 32'(rvq[0].data));
                rvq.pop_front();
            end
            check("rnd_rvalid", 32'(rvalid), 32'(erv));
            for (int i = 0; i < NUM_CH; i++) begin
                if (gnt[i]) begin
                    $display("rnd txn ch%0d %s addr=%05h wdata=%04h be=%b", i,
                             c_we[i] ? "WR" : "RD", c_addr[i], c_wd[i], c_be[i]);
                    c_act[i] = 1'b0;
                    if (cyc < RND_CYC && $urandom_range(0, 1) == 1) new_req(i);
                end else if (c_act[i]) begin
                    if (cyc >= RND_CYC || $urandom_range(0, 31) == 0) c_act[i] = 1'b0;
                end else if (cyc < RND_CYC && $urandom_range(0, 3) == 0) begin
                    new_req(i);
                end
            end
            drive_clients();
        end
        check("rnd_drain", 32'(rvq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
